// File: rtl/cube_pin_capture_pkg.sv
// Shared cube bus definitions: pin field positions, frame geometry and slot decode.
// The cube output driver builds its bus from these same constants.
package cube_pin_capture_pkg;

    localparam int PIN_W      = 15;
    localparam int LAYER_MSB  = 14;
    localparam int LAYER_LSB  = 12;
    localparam int COL_MSB    = 11;
    localparam int COL_LSB    = 9;
    localparam int STROBE_BIT = 8;
    localparam int DATA_MSB   = 7;

    localparam int CUBE_DIM   = 8;
    localparam int SLOTS      = CUBE_DIM * CUBE_DIM;
    localparam int FRAME_BITS = SLOTS * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PUBLISH
    } cap_state_t;

    // slot = layer*8 + col; both fields are 3 bits, so this is a concatenation.
    function automatic logic [5:0] slot_index(input logic [PIN_W-1:0] pins);
        return {pins[LAYER_MSB:LAYER_LSB], pins[COL_MSB:COL_LSB]};
    endfunction

endpackage

// File: rtl/cube_pin_capture_if.sv
// Cube pin bus plus captured-frame status, as seen by a driver (master)
// and by the capture block (slave).
interface cube_pin_capture_if;
    import cube_pin_capture_pkg::*;

    logic [PIN_W-1:0]      Pins;
    logic [FRAME_BITS-1:0] Cells;
    logic                  frame_valid;
    logic [15:0]           frame_count;
    logic                  busy;
    logic                  dup_err;
    logic                  timeout_err;

    modport master (
        output Pins,
        input  Cells, frame_valid, frame_count, busy, dup_err, timeout_err
    );

    modport slave (
        input  Pins,
        output Cells, frame_valid, frame_count, busy, dup_err, timeout_err
    );

endinterface

// File: rtl/cube_bus_sync.sv
// Pin synchronizer chain plus latch-strobe rising-edge detect.
// A strobe already high when reset releases must fall before it can fire again.
module cube_bus_sync
    import cube_pin_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PIN_W-1:0] i_pins,
    output logic [PIN_W-1:0] o_sp,
    output logic             o_event
);

    logic w_live;
    logic r_strobe_prev;
    logic r_armed;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign o_sp   = i_pins;
            assign w_live = 1'b1;
        end else begin : g_sync
            // Top bit marks stages that hold a real sample rather than reset zeros.
            logic [PIN_W:0] r_chain [SYNC_STAGES];

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
                end else begin
                    r_chain[0] <= {1'b1, i_pins};
                    for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
                end
            end

            assign o_sp   = r_chain[SYNC_STAGES-1][PIN_W-1:0];
            assign w_live = r_chain[SYNC_STAGES-1][PIN_W];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_strobe_prev <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_strobe_prev <= o_sp[STROBE_BIT];
            if (w_live && !o_sp[STROBE_BIT]) r_armed <= 1'b1;
        end
    end

    assign o_event = o_sp[STROBE_BIT] & ~r_strobe_prev & r_armed;

endmodule

// File: rtl/cube_pin_capture.sv
// Reassembles strobed cube bus bytes into 512-bit frames and publishes them.
//   state      | meaning
//   ST_IDLE    | no slot written in the current frame (coverage = 0)
//   ST_FILL    | partial frame in progress
//   ST_PUBLISH | one cycle: Cells just loaded, frame_valid high
module cube_pin_capture
    import cube_pin_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65536
) (
    input  logic               Clk,
    input  logic               Reset,
    cube_pin_capture_if.slave  bus
);

    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [PIN_W-1:0]      w_sp;
    logic                  w_event;
    logic [5:0]            w_slot;
    logic [SLOTS-1:0]      w_cov_set;
    logic [FRAME_BITS-1:0] w_working_next;
    logic                  w_full;
    logic                  w_load;
    logic                  w_drop;
    cap_state_t            r_state;
    cap_state_t            w_state_next;

    logic [FRAME_BITS-1:0] r_working;
    logic [FRAME_BITS-1:0] r_cells;
    logic [SLOTS-1:0]      r_coverage;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic [15:0]           r_frame_count;
    logic                  r_dup_err;
    logic                  r_timeout_err;

    cube_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_pins  (bus.Pins),
        .o_sp    (w_sp),
        .o_event (w_event)
    );

    assign w_slot = slot_index(w_sp);

    always_comb begin
        w_working_next = r_working;
        w_cov_set      = r_coverage;
        if (w_event) begin
            w_working_next[{w_slot, 3'b000} +: 8] = w_sp[DATA_MSB:0];
            w_cov_set[w_slot]                     = 1'b1;
        end
    end

    assign w_full = &w_cov_set;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // An event always beats a timeout landing on the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE, ST_PUBLISH: begin
                if (w_event) w_state_next = ST_FILL;
                else         w_state_next = ST_IDLE;
            end
            ST_FILL: begin
                if (w_event && w_full) begin
                    w_state_next = ST_PUBLISH;
                    w_load       = 1'b1;
                end else if (!w_event && r_idle_cnt == IDLE_MAX) begin
                    w_state_next = ST_IDLE;
                    w_drop       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_working     <= '0;
            r_cells       <= '0;
            r_coverage    <= '0;
            r_idle_cnt    <= '0;
            r_frame_count <= '0;
            r_dup_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_working     <= w_working_next;
            r_coverage    <= (w_load || w_drop) ? '0 : w_cov_set;
            r_timeout_err <= w_drop;
            if (w_load) begin
                r_cells       <= w_working_next;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_event && r_coverage[w_slot]) r_dup_err <= 1'b1;
            if (w_event)                       r_idle_cnt <= '0;
            else if (r_idle_cnt != IDLE_MAX)   r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign bus.Cells       = r_cells;
    assign bus.frame_valid = (r_state == ST_PUBLISH);
    assign bus.frame_count = r_frame_count;
    assign bus.busy        = |r_coverage;
    assign bus.dup_err     = r_dup_err;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cube_pin_capture.sv
// Randomized bench for cube_pin_capture: a byte-slot model queues expected frames,
// a negedge monitor compares each published frame.
module tb_cube_pin_capture;

    localparam int SYNC = 2;
    localparam int TMO  = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cube_pin_capture_if bus ();

    cube_pin_capture #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [511:0] cells;
        logic [15:0]  cnt;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   m_bytes [64];
    bit           m_cov   [64];
    logic [15:0]  m_count;
    logic [511:0] m_last_cells;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;
    int n_to     = 0;
    int cyc      = 0;
    int to_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_cells();
        logic [511:0] c;
        for (int s = 0; s < 64; s++) c[s*8 +: 8] = m_bytes[s];
        return c;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            m_bytes[s] = 8'h00;
            m_cov[s]   = 1'b0;
        end
        m_count      = 16'd0;
        m_last_cells = '0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end
            if (bus.frame_valid) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got frame_valid with count %0d, expected none", bus.frame_count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_cells", bus.Cells, e.cells);
                    chk("frame_count_at_valid", 512'(bus.frame_count), 512'(e.cnt));
                end
            end
        end
    end

    // Issue one strobe event and apply the model's byte-slot rules.
    task automatic strobe(input int slot, input logic [7:0] d, input int hold);
        logic [5:0] s;
        bit         all;
        s = slot[5:0];
        @(posedge clk); #1;
        bus.Pins = {s[5:3], s[2:0], 1'b1, d};
        repeat (hold) @(posedge clk);
        #1 bus.Pins[8] = 1'b0;
        m_bytes[slot] = d;
        m_cov[slot]   = 1'b1;
        all = 1'b1;
        for (int i = 0; i < 64; i++) if (!m_cov[i]) all = 1'b0;
        if (all) begin
            exp_t e;
            m_count      = m_count + 16'd1;
            m_last_cells = model_cells();
            e.cells      = m_last_cells;
            e.cnt        = m_count;
            exp_q.push_back(e);
            for (int i = 0; i < 64; i++) m_cov[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        bus.Pins = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic settle();
        repeat (SYNC + 6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_cells"},       bus.Cells, '0);
        chk({tag, "_count"},       512'(bus.frame_count), '0);
        chk({tag, "_busy"},        512'(bus.busy), '0);
        chk({tag, "_dup"},         512'(bus.dup_err), '0);
        chk({tag, "_valid"},       512'(bus.frame_valid), '0);
        chk({tag, "_timeout_err"}, 512'(bus.timeout_err), '0);
    endtask

    initial begin
        int           order[64];
        int           f0;
        int           t0;
        logic [7:0]   pat;

        bus.Pins = '0;
        model_clear();
        do_reset();
        check_reset_values("reset");

        // Ascending full frame, data = slot index.
        for (int s = 0; s < 64; s++) strobe(s, 8'(s), 1);
        settle();
        chk("asc_frames",     512'(n_frames), 512'd1);
        chk("asc_lo_byte",    512'(bus.Cells[7:0]), 512'h00);
        chk("asc_hi_byte",    512'(bus.Cells[511:504]), 512'h3F);
        chk("asc_count",      512'(bus.frame_count), 512'd1);
        chk("asc_dup",        512'(bus.dup_err), 512'd0);
        chk("asc_busy_after", 512'(bus.busy), 512'd0);

        // Strobe level held for 5 cycles must be a single event.
        strobe(0, 8'hA5, 5);
        settle();
        chk("hold_busy", 512'(bus.busy), 512'd1);
        chk("hold_no_frame", 512'(n_frames), 512'd1);
        for (int i = 0; i < 63; i++) order[i] = i + 1;
        for (int i = 62; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 63; i++) strobe(order[i], 8'($urandom), 1);
        settle();
        chk("hold_frames", 512'(n_frames), 512'd2);
        chk("hold_dup",    512'(bus.dup_err), 512'd0);
        chk("hold_slot0",  512'(bus.Cells[7:0]), 512'hA5);

        // Duplicate write to slot 9.
        strobe(9, 8'h11, 1);
        strobe(9, 8'h22, 1);
        settle();
        chk("dup_set", 512'(bus.dup_err), 512'd1);
        for (int s = 0; s < 64; s++) if (s != 9) strobe(s, 8'($urandom), 1);
        settle();
        chk("dup_sticky", 512'(bus.dup_err), 512'd1);
        chk("dup_slot9",  512'(bus.Cells[79:72]), 512'h22);
        chk("dup_count",  512'(bus.frame_count), 512'd3);

        // Partial frame abandoned by the idle timeout.
        f0 = n_frames;
        for (int s = 0; s < 9; s++) strobe(s, 8'($urandom), 1);
        @(posedge clk); #1;
        bus.Pins = {3'd1, 3'd1, 1'b1, 8'h5A};
        t0 = cyc;
        m_bytes[9] = 8'h5A;
        @(posedge clk); #1 bus.Pins[8] = 1'b0;
        repeat (TMO + 40) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 64; s++) m_cov[s] = 1'b0;
        chk("to_pulses",  512'(n_to), 512'd1);
        chk("to_latency_in_window",
            512'((to_cyc - t0 >= TMO + 3) && (to_cyc - t0 <= TMO + 5)), 512'd1);
        chk("to_busy",    512'(bus.busy), 512'd0);
        chk("to_count",   512'(bus.frame_count), 512'd3);
        chk("to_cells",   bus.Cells, m_last_cells);
        chk("to_no_frame", 512'(n_frames), 512'(f0));
        chk("to_dup_sticky", 512'(bus.dup_err), 512'd1);

        // Three frames back to back after a fresh reset.
        do_reset();
        check_reset_values("reset2");
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 64; s++) begin
                pat = (f == 0) ? 8'hFF : (f == 1) ? 8'h00 : (s[0] ? 8'h55 : 8'hAA);
                strobe(s, pat, 1);
            end
        end
        settle();
        chk("b2b_count", 512'(bus.frame_count), 512'd3);
        chk("b2b_slot0", 512'(bus.Cells[7:0]), 512'hAA);
        chk("b2b_slot1", 512'(bus.Cells[15:8]), 512'h55);
        chk("b2b_dup",   512'(bus.dup_err), 512'd0);

        // Reset in the middle of a frame.
        for (int s = 0; s < 30; s++) strobe(s, 8'($urandom), 1);
        settle();
        chk("mid_busy", 512'(bus.busy), 512'd1);
        do_reset();
        check_reset_values("reset_mid");
        for (int s = 63; s >= 0; s--) strobe(s, 8'($urandom), 1);
        settle();
        chk("post_reset_count", 512'(bus.frame_count), 512'd1);
        chk("post_reset_busy",  512'(bus.busy), 512'd0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("exp_queue_drained", 512'(exp_q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected test end");
        $fatal(1);
    end

endmodule

// File: doc/cube_pin_capture.md
Name: cube_pin_capture

Overview:
- Receive-side decoder for the 15-bit multiplexed LED-cube pin bus (8 data pins, 7 select/enable pins) produced by the cube output driver.
- Watches strobe events, reassembles the scanned bytes into a 512-bit cell frame and publishes each complete frame with a valid pulse.
- Used as the on-board loopback monitor (pins wired back in) and as the scoreboard front end in cube output benches.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on Pins (0 = same-clock source, no sync)
- TIMEOUT, 65536, Clk cycles without a strobe before a partial frame is discarded

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Pins  input  15  cube bus: [14:12] layer select, [11:9] column-latch select, [8] latch strobe, [7:0] data
- Cells  output  512  last complete captured frame
- frame_valid  output  1  one-cycle pulse when Cells updates
- frame_count  output  16  completed frames, wraps 0xFFFF->0
- busy  output  1  partial frame in progress (coverage nonzero)
- dup_err  output  1  sticky: a byte slot was written twice within one frame
- timeout_err  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (synchronous, active-high): Cells=0, frame_valid=0, frame_count=0, busy=0, dup_err=0, timeout_err=0; coverage, working buffer, idle counter and sync flops cleared; strobe history=0.
- Input path: Pins passes through SYNC_STAGES flops; all decode uses the synchronized copy (sp).
- Strobe event: sp[8]=1 and previous-cycle sp[8]=0 (rising edge). Level high for several cycles = one event.
- On event: slot = sp[14:12]*8 + sp[11:9] (0..63); working[slot*8 +: 8] <= sp[7:0], i.e. Cells bit layer*64+col*8+k = Pins[k]; coverage[slot] <= 1.
- Duplicate: event to a slot whose coverage bit is already set overwrites the byte and sets dup_err (held until Reset).
- Completion: on the cycle the event makes coverage all-ones, next cycle Cells = working (including that byte), frame_valid=1 for one cycle, frame_count+1, coverage cleared. Latency is strobe edge at sp -> frame_valid in 1 Clk, plus SYNC_STAGES+1 from the Pins pin.
- Working buffer is not cleared between frames; Cells changes only on completion.
- Idle counter: cleared on every event and on completion; increments otherwise, saturating at TIMEOUT. When it reaches TIMEOUT with coverage nonzero: coverage cleared, timeout_err pulses once, busy=0; Cells unchanged. If coverage is zero, no pulse.
- Event on the same cycle as timeout: the event wins; counter clears, no timeout.
- busy = |coverage (registered with coverage).
- Reset mid-frame discards the partial frame; a strobe already high at reset release is not an event until it falls and rises again.
- FSM: IDLE (coverage=0) -> FILL on first event -> PUBLISH on last slot (1 cycle) -> IDLE; FILL -> IDLE on timeout.

Decomposition:
- Shared cube package: bus field positions (LAYER_MSB/LSB=14/12, COL_MSB/LSB=11/9, STROBE_BIT=8, DATA_MSB=7), CUBE_DIM=8, SLOTS=64, FRAME_BITS=512, slot index function; the same constants are used by the cube output driver.
- One sub-module: cube_bus_sync (SYNC_STAGES flop chain plus strobe rising-edge detect, outputs synced bus and event pulse).

Test Plan:
- Reset, then 64 strobes with layer/col ascending and data=slot index -> exactly one frame_valid; Cells[7:0]=0x00, Cells[511:504]=0x3F; frame_count=1; dup_err=0.
- Strobe held high 5 cycles on slot 0 with data 0xA5 -> one event only; busy=1; coverage bit 0 only.
- Slot 9 written 0x11 then 0x22 in the same frame, then the rest filled -> dup_err=1 sticky; Cells[79:72]=0x22.
- 10 slots written, then no strobe for TIMEOUT cycles -> timeout_err pulses once at idle count TIMEOUT; busy=0; Cells and frame_count unchanged.
- Three full frames back to back with patterns all-0xFF, all-0x00 and checkerboard 0xAA/0x55 -> three frame_valid pulses; Cells matches each pattern; frame_count=3.
- Reset asserted after 30 slots -> all outputs return to reset values; a following full frame gives frame_count=1 and correct Cells.
